// File: rtl/tick_feature_window.sv
// Sliding window of saturated Q8.8 tick-to-tick price deltas, presented as a flat feature vector.
// Optional build macro TFW_SAT_CNT_EN adds a saturating count of clipped deltas on port sat_count.
module tick_feature_window #(
    parameter int unsigned PRICE_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAC_BITS    = 8,
    parameter int unsigned NUM_FEATURES = 16,
    localparam int unsigned CNT_W       = $clog2(NUM_FEATURES + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PRICE_WIDTH-1:0]             in_price,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_FEATURES*DATA_WIDTH-1:0] features_flat,
    output logic [CNT_W-1:0]                   fill_count
`ifdef TFW_SAT_CNT_EN
    ,
    output logic [15:0]                        sat_count
`endif
);

    localparam logic signed [PRICE_WIDTH:0] D_MAX =
        $signed((PRICE_WIDTH+1)'((64'd1 << (DATA_WIDTH - 1)) - 64'd1));
    localparam logic signed [PRICE_WIDTH:0] D_MIN = ~D_MAX;
    localparam logic [DATA_WIDTH-1:0]       SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]       SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]            FILL_MAX = CNT_W'(NUM_FEATURES);

    if (NUM_FEATURES < 2 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
        $error("tick_feature_window: unsupported parameter set");
    end

    logic [DATA_WIDTH-1:0]        win [NUM_FEATURES];
    logic [PRICE_WIDTH-1:0]       prev_price;
    logic                         have_prev;

    logic                         accept;
    logic                         take_delta;
    logic                         clipped;
    logic signed [PRICE_WIDTH:0]  delta;
    logic [DATA_WIDTH-1:0]        delta_sat;
    logic [CNT_W-1:0]             fill_next;

    // Backpressure only while an unconsumed vector is held; clear blocks intake.
    assign in_ready   = !rst && !clear && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign take_delta = accept && have_prev;

    // Delta in (PRICE_WIDTH+1)-bit signed arithmetic, clipped to the feature range.
    always_comb begin
        delta     = $signed({1'b0, in_price}) - $signed({1'b0, prev_price});
        clipped   = 1'b0;
        delta_sat = DATA_WIDTH'(delta);
        if (delta > D_MAX) begin
            delta_sat = SAT_POS;
            clipped   = 1'b1;
        end else if (delta < D_MIN) begin
            delta_sat = SAT_NEG;
            clipped   = 1'b1;
        end
        fill_next = (fill_count == FILL_MAX) ? fill_count : fill_count + 1'b1;
    end

    // Window shift register and tick bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_FEATURES; k++) win[k] <= '0;
            prev_price <= '0;
            have_prev  <= 1'b0;
            fill_count <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_FEATURES; k++) win[k] <= '0;
            prev_price <= '0;
            have_prev  <= 1'b0;
            fill_count <= '0;
        end else if (accept) begin
            prev_price <= in_price;
            have_prev  <= 1'b1;
            if (have_prev) begin
                for (int k = NUM_FEATURES - 1; k > 0; k--) win[k] <= win[k-1];
                win[0]     <= delta_sat;
                fill_count <= fill_next;
            end
        end
    end

    // A new full vector replaces the old one on the same edge it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (take_delta && fill_next == FILL_MAX) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_FEATURES; k++) begin : g_flat
        assign features_flat[k*DATA_WIDTH +: DATA_WIDTH] = win[k];
    end

`ifdef TFW_SAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (clear) begin
            sat_count <= '0;
        end else if (take_delta && clipped && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_feature_window.sv
// Randomized and directed bench for tick_feature_window against a queue-based reference model.
module tb_tick_feature_window;

    localparam int NF = 16;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    in_price = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [NF*DW-1:0] features_flat;
    logic [4:0]     fill_count;
`ifdef TFW_SAT_CNT_EN
    logic [15:0]    sat_count;
`endif

    tick_feature_window dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_price(in_price),
        .out_valid(out_valid), .out_ready(out_ready),
        .features_flat(features_flat), .fill_count(fill_count)
`ifdef TFW_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: queue of deltas, newest first.
    int          m_q[$];
    logic [31:0] m_prev;
    bit          m_have;
    bit          m_ov;
    int          m_sat;

    function automatic logic [255:0] exp_flat();
        logic [255:0] f = '0;
        for (int k = 0; k < m_q.size(); k++) f[k*DW +: DW] = 16'(m_q[k]);
        return f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev = '0;
        m_have = 0;
        m_ov   = 0;
        m_sat  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ov"},   256'(out_valid), 256'(m_ov));
        check({tag, "_fill"}, 256'(fill_count), 256'(m_q.size()));
        check({tag, "_flat"}, features_flat, exp_flat());
`ifdef TFW_SAT_CNT_EN
        check({tag, "_sat"},  256'(sat_count), 256'(m_sat));
`endif
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs after the edge.
    task automatic step(input bit v, input logic [31:0] p, input bit r, input bit c, input string tag);
        bit exp_ready, acc, made_full;
        longint d;
        in_valid = v; in_price = p; out_ready = r; clear = c;
        #1;
        exp_ready = !c && (!m_ov || r);
        check({tag, "_rdy"}, 256'(in_ready), 256'(exp_ready));
        acc = v && exp_ready;
        made_full = 0;
        if (c) begin
            model_reset();
        end else if (acc) begin
            if (m_have) begin
                d = longint'(p) - longint'(m_prev);
                if (d > 32767 || d < -32768) begin
                    d = (d > 0) ? 32767 : -32768;
                    if (m_sat < 65535) m_sat++;
                end
                m_q.push_front(int'(d));
                if (m_q.size() > NF) void'(m_q.pop_back());
                made_full = (m_q.size() == NF);
            end
            m_prev = p;
            m_have = 1;
        end
        if (!c) begin
            if (made_full) m_ov = 1;
            else if (r) m_ov = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    logic [31:0]  price;
    logic [255:0] held;

    initial begin
        model_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 256'(in_ready), 256'(0));
        check_outputs("reset");
        rst = 1'b0;

        // Fill: 17 ticks, half-point steps.
        for (int i = 0; i < 17; i++) begin
            step(1, 32'h6400 + 32'(i) * 32'h80, 1, 0, "fill");
            if (i == 15) check("fill_not_yet", 256'(out_valid), 256'(0));
        end
        check("fill_first_ov", 256'(out_valid), 256'(1));
        check("fill_all_0080", features_flat, {16{16'h0080}});
        check("fill_cnt16", 256'(fill_count), 256'(16));

        // Saturation both directions.
        step(0, 0, 1, 1, "satclr");
        step(1, 32'h6400, 1, 0, "sat");
        step(1, 32'h12C00, 1, 0, "sat");
        step(1, 32'h6400, 1, 0, "sat");
        check("sat_w0", 256'(features_flat[15:0]), 256'(16'h8000));
        check("sat_w1", 256'(features_flat[31:16]), 256'(16'h7FFF));

        // Backpressure on a full window.
        price = 32'h6400;
        for (int i = 0; i < 16; i++) begin
            price = price + 32'($urandom_range(0, 'h300)) - 32'h180;
            step(1, price, 1, 0, "bpfill");
        end
        held = features_flat;
        for (int i = 0; i < 5; i++) step(1, price + 32'h40, 0, 0, "bphold");
        check("bp_flat_held", features_flat, held);
        for (int i = 0; i < 4; i++) begin
            price = price + 32'h40;
            step(1, price, 1, 0, "bprel");
        end

        // Streaming at full rate.
        for (int i = 0; i < 20; i++) begin
            price = price + 32'($urandom_range(0, 'h400)) - 32'h200;
            step(1, price, 1, 0, "stream");
        end

        // Clear with a concurrent tick while full.
        step(1, price + 32'h100, 0, 1, "clr");
        check("clr_fill0", 256'(fill_count), 256'(0));
        step(1, price, 1, 0, "clrseed");
        check("clrseed_ov", 256'(out_valid), 256'(0));

        // Random mixed traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) price = $urandom();
            else price = price + 32'($urandom_range(0, 'h200)) - 32'h100;
            step(($urandom_range(0, 3) != 0), price, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0), "rand");
        end

        // Ensure out_valid is high, then reset asynchronously between edges.
        for (int i = 0; i < 17; i++) begin
            price = price + 32'h20;
            step(1, price, 1, 0, "prerst");
        end
        check("prerst_ov", 256'(out_valid), 256'(1));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_rdy", 256'(in_ready), 256'(0));
        check_outputs("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            price = price + 32'h10;
            step(1, price, 1, 0, "postrst");
            if (i == 15) check("postrst_not_yet", 256'(out_valid), 256'(0));
        end
        check("postrst_ov", 256'(out_valid), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
